program_memory_ctrl: RTL and testbench

Parametrised, writable instruction memory for the uProcessor core, replacing the fixed 32 x 13 initialised ROM. It serves the fetch path with a registered, one-cycle read. After reset it clears itself to NOP. It accepts a new program over a valid/ready load port, so test programs are streamed in by the bench or a loader rather than compiled into the memory. It also reports word count, an XOR checksum and an overflow error for each load.

---
 rtl/program_memory_ctrl_if.sv | 33 +++
 rtl/program_memory_ctrl.sv | 119 +++++++++++
 tb/tb_program_memory_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_ctrl_if.sv
// Fetch and program-load bus of the writable instruction memory.
// The core or loader drives it through master; the memory uses slave.
interface program_memory_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int INS_W  = 13
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic              busy;
    logic              load_start;
    logic              load_valid;
    logic [INS_W-1:0]  load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic [INS_W-1:0]  load_xsum;
    logic              load_err;

    modport master (
        output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
        input  ins_out, ins_valid, busy, load_ready, load_done, load_count,
               load_xsum, load_err
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
        output ins_out, ins_valid, busy, load_ready, load_done, load_count,
               load_xsum, load_err
    );
endinterface

// File: rtl/program_memory_ctrl.sv
// Writable instruction memory with self-clear after reset, registered
// one-cycle fetch, and a valid/ready program load port that reports
// word count, XOR checksum and overflow.
//
// state | meaning
// ------+---------------------------------------------------------
// CLEAR | fill every location with NOP_WORD, one per cycle; busy
// IDLE  | serve fetches; wait for load_start
// LOAD  | accept program words into mem[0..]; busy, load_ready high
module program_memory_ctrl #(
    parameter int                ADDR_W   = 5,
    parameter int                INS_W    = 13,
    parameter logic [INS_W-1:0]  NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    program_memory_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [INS_W-1:0]  mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [INS_W-1:0]  mem_wdata;

    // Single write port shared by the clear sweep and the program load.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = NOP_WORD;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
            end else if (state == LOAD && bus.load_valid) begin
                mem_we    = 1'b1;
                mem_waddr = bus.load_count[ADDR_W-1:0];
                mem_wdata = bus.load_data;
            end
        end
    end

    // Storage array; contents are rebuilt by CLEAR, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= CLEAR;
            ptr            <= '0;
            bus.ins_out    <= NOP_WORD;
            bus.ins_valid  <= 1'b0;
            bus.busy       <= 1'b1;
            bus.load_ready <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.load_count <= '0;
            bus.load_xsum  <= '0;
            bus.load_err   <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            case (state)
                CLEAR: begin
                    bus.ins_valid <= 1'b0;
                    ptr           <= ptr + 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.load_start) begin
                        // a fetch in the same cycle is dropped
                        state          <= LOAD;
                        bus.busy       <= 1'b1;
                        bus.load_ready <= 1'b1;
                        bus.ins_valid  <= 1'b0;
                        bus.load_count <= '0;
                        bus.load_xsum  <= '0;
                        bus.load_err   <= 1'b0;
                    end else if (bus.fetch_en) begin
                        bus.ins_out   <= mem[bus.fetch_addr];
                        bus.ins_valid <= 1'b1;
                    end else begin
                        bus.ins_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    bus.ins_valid <= 1'b0;
                    if (bus.load_valid) begin
                        bus.load_count <= bus.load_count + (ADDR_W + 1)'(1);
                        bus.load_xsum  <= bus.load_xsum ^ bus.load_data;
                        // final word either flagged or the one that fills the memory
                        if (bus.load_last || (bus.load_count[ADDR_W-1:0] == ADDR_W'(DEPTH - 1))) begin
                            state          <= IDLE;
                            bus.busy       <= 1'b0;
                            bus.load_ready <= 1'b0;
                            bus.load_done  <= 1'b1;
                            bus.load_err   <= ~bus.load_last;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_memory_ctrl.sv
// Self-checking bench for program_memory_ctrl: clear timing, fetch
// scoreboard, gap-free/gapped/overflow loads, reset mid-load, and
// load_start vs fetch_en priority.
module tb_program_memory_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    program_memory_ctrl_if #(.ADDR_W(5), .INS_W(13)) bus ();

    program_memory_ctrl #(.ADDR_W(5), .INS_W(13), .NOP_WORD(13'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [12:0] exp_ins;
    } fetch_vec_t;

    int errors = 0;
    int checks = 0;
    logic [12:0] model_mem [32];
    logic [12:0] exp_q [$];
    logic [12:0] words [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one result is due each cycle after a fetch was issued
    task automatic check_out();
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fetch_valid", int'(bus.ins_valid), 1);
            chk("fetch_data", int'(bus.ins_out), int'(e));
        end else begin
            chk("no_fetch_valid", int'(bus.ins_valid), 0);
        end
    endtask

    task automatic issue_fetch(input logic [4:0] a, input logic [12:0] e);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = a;
        exp_q.push_back(e);
        tick();
        check_out();
    endtask

    task automatic fetch_end();
        bus.fetch_en = 1'b0;
        tick();
        check_out();
        chk("fetch_q_empty", exp_q.size(), 0);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk(name, n, 32);
    endtask

    task automatic do_load(input bit gaps, input bit with_last, output int cycles);
        logic [12:0] xs = '0;
        int n = words.size();
        cycles = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("ready_after_start", int'(bus.load_ready), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                bus.load_valid = 1'b0;
                tick();
                cycles++;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = with_last && (i == n - 1);
            tick();
            cycles++;
            model_mem[i] = words[i];
            xs ^= words[i];
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("done_pulse", int'(bus.load_done), 1);
        chk("done_busy", int'(bus.busy), 0);
        chk("done_ready", int'(bus.load_ready), 0);
        chk("load_count", int'(bus.load_count), n);
        chk("load_xsum", int'(bus.load_xsum), int'(xs));
        chk("load_err", int'(bus.load_err), (!with_last && n == 32) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        fetch_vec_t vecs_a [6];
        int cyc_a, cyc_b;

        vecs_a[0] = '{5'd0,  13'h0101};
        vecs_a[1] = '{5'd1,  13'h0A02};
        vecs_a[2] = '{5'd2,  13'h1FFF};
        vecs_a[3] = '{5'd3,  13'h0000};
        vecs_a[4] = '{5'd31, 13'h0000};
        vecs_a[5] = '{5'd7,  13'h0000};

        bus.fetch_en = 0; bus.fetch_addr = 0; bus.load_start = 0;
        bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = 13'h0000;

        // reset state
        tick(); tick();
        chk("rst_busy", int'(bus.busy), 1);
        chk("rst_ins_out", int'(bus.ins_out), 0);
        chk("rst_ins_valid", int'(bus.ins_valid), 0);
        chk("rst_ready", int'(bus.load_ready), 0);
        chk("rst_done", int'(bus.load_done), 0);
        chk("rst_count", int'(bus.load_count), 0);
        rst = 1'b0;
        wait_clear("clear_cycles");

        issue_fetch(5'd7, 13'h0000);
        fetch_end();

        // gap-free load with last on the third word
        words = '{13'h0101, 13'h0A02, 13'h1FFF};
        do_load(1'b0, 1'b1, cyc_a);
        chk("xsum_const", int'(bus.load_xsum), 13'h14FC);
        issue_fetch(5'd1, 13'h0A02);
        chk("done_cleared", int'(bus.load_done), 0);
        for (int i = 0; i < 6; i++) issue_fetch(vecs_a[i].addr, vecs_a[i].exp_ins);
        fetch_end();

        // overflow: 32 words, no last
        words = {};
        for (int i = 0; i < 32; i++) words.push_back(13'(i));
        do_load(1'b0, 1'b0, cyc_b);
        bus.load_valid = 1'b1;
        bus.load_data  = 13'h1234;
        tick();
        bus.load_valid = 1'b0;
        chk("ovf_extra_count", int'(bus.load_count), 32);
        chk("ovf_extra_err", int'(bus.load_err), 1);
        chk("ovf_extra_ready", int'(bus.load_ready), 0);
        issue_fetch(5'd31, 13'h001F);
        issue_fetch(5'd0, model_mem[0]);
        fetch_end();

        // gapped load over the overflow contents; word 3 keeps old value
        words = '{13'h0101, 13'h0A02, 13'h1FFF};
        do_load(1'b1, 1'b1, cyc_b);
        chk("gap_latency", cyc_b - cyc_a, 2);
        for (int i = 0; i < 6; i++) issue_fetch(5'(i), model_mem[i]);
        issue_fetch(5'd31, model_mem[31]);
        fetch_end();

        // start and fetch together: load wins
        bus.load_start = 1'b1;
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 5'd5;
        tick();
        bus.load_start = 1'b0;
        bus.fetch_en   = 1'b0;
        chk("prio_valid", int'(bus.ins_valid), 0);
        chk("prio_ready", int'(bus.load_ready), 1);
        chk("prio_count", int'(bus.load_count), 0);
        bus.load_valid = 1'b1; bus.load_data = 13'h0777; bus.load_last = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        model_mem[0] = 13'h0777;
        chk("prio_done", int'(bus.load_done), 1);
        chk("prio_no_fetch", int'(bus.ins_valid), 0);
        issue_fetch(5'd0, 13'h0777);
        fetch_end();

        // reset after two accepted words
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 13'h0AAA;
        tick(); tick();
        bus.load_valid = 1'b0;
        chk("mid_count", int'(bus.load_count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = 13'h0000;
        wait_clear("reclear_cycles");
        chk("reclear_count", int'(bus.load_count), 0);
        issue_fetch(5'd0, 13'h0000);
        issue_fetch(5'd1, 13'h0000);
        issue_fetch(5'd31, 13'h0000);
        fetch_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
